// File: rtl/sram_port_arbiter_if.sv
// Bundle of both requester ports and the SRAM macro side of sram_port_arbiter.
// slave is the arbiter view; master is the requesters-plus-SRAM view.
interface sram_port_arbiter_if #(
    parameter int W_ADDR = 11,
    parameter int W_DATA = 32
);
    localparam int W_BE = W_DATA / 8;

    logic              p0_req;
    logic [W_BE-1:0]   p0_wen;
    logic [W_ADDR-1:0] p0_addr;
    logic [W_DATA-1:0] p0_wdata;
    logic              p0_lock;
    logic              p0_gnt;
    logic              p0_rvalid;
    logic [W_DATA-1:0] p0_rdata;

    logic              p1_req;
    logic [W_BE-1:0]   p1_wen;
    logic [W_ADDR-1:0] p1_addr;
    logic [W_DATA-1:0] p1_wdata;
    logic              p1_lock;
    logic              p1_gnt;
    logic              p1_rvalid;
    logic [W_DATA-1:0] p1_rdata;

    logic              sram_ren;
    logic [W_BE-1:0]   sram_wen;
    logic [W_ADDR-1:0] sram_addr;
    logic [W_DATA-1:0] sram_wdata;
    logic [W_DATA-1:0] sram_rdata;

    modport slave (
        input  p0_req, p0_wen, p0_addr, p0_wdata, p0_lock,
        output p0_gnt, p0_rvalid, p0_rdata,
        input  p1_req, p1_wen, p1_addr, p1_wdata, p1_lock,
        output p1_gnt, p1_rvalid, p1_rdata,
        output sram_ren, sram_wen, sram_addr, sram_wdata,
        input  sram_rdata
    );

    modport master (
        output p0_req, p0_wen, p0_addr, p0_wdata, p0_lock,
        input  p0_gnt, p0_rvalid, p0_rdata,
        output p1_req, p1_wen, p1_addr, p1_wdata, p1_lock,
        input  p1_gnt, p1_rvalid, p1_rdata,
        input  sram_ren, sram_wen, sram_addr, sram_wdata,
        output sram_rdata
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port SRAM, with write-to-read forwarding.
// Define SRAM_ARB_LOCK_EN to honour pX_lock (bounded by LOCK_MAX consecutive locked grants).
module sram_port_arbiter #(
    parameter int W_ADDR   = 11,
    parameter int W_DATA   = 32,
    parameter int LOCK_MAX = 16
) (
    input logic                clk,
    input logic                rst,
    sram_port_arbiter_if.slave bus
);
    localparam int W_BE = W_DATA / 8;

    logic              grant;
    logic              sel;
    logic [W_BE-1:0]   g_wen;
    logic [W_ADDR-1:0] g_addr;
    logic [W_DATA-1:0] g_wdata;
    logic              last;
    logic              lock_hold;

    logic              tag_valid;
    logic              tag_port;
    logic [W_BE-1:0]   tag_mask;
    logic [W_DATA-1:0] tag_data;
    logic [W_DATA-1:0] merged;

    logic              fwd_valid;
    logic [W_ADDR-1:0] fwd_addr;
    logic [W_DATA-1:0] fwd_data;
    logic [W_BE-1:0]   fwd_mask;

`ifdef SRAM_ARB_LOCK_EN
    localparam int W_CNT = $clog2(LOCK_MAX + 1);

    typedef enum logic {LK_IDLE, LK_HELD} lock_state_t;
    lock_state_t       lock_state;
    lock_state_t       lock_next;
    logic              lock_port;
    logic [W_CNT-1:0]  lock_cnt;
    logic              g_lock;

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_state <= LK_IDLE;
            lock_port  <= 1'b0;
            lock_cnt   <= '0;
        end else begin
            lock_state <= lock_next;
            lock_port  <= sel;
            if (grant && lock_hold) begin
                if (lock_cnt != W_CNT'(LOCK_MAX))
                    lock_cnt <= lock_cnt + 1'b1;
            end else begin
                lock_cnt <= '0;
            end
        end
    end

    // Kept apart from lock_next so the grant select never loops through itself.
    always_comb begin
        lock_hold = 1'b0;
        if (lock_state == LK_HELD) begin
            if (lock_port)
                lock_hold = bus.p1_req && !((lock_cnt == W_CNT'(LOCK_MAX)) && bus.p0_req);
            else
                lock_hold = bus.p0_req && !((lock_cnt == W_CNT'(LOCK_MAX)) && bus.p1_req);
        end
    end

    always_comb begin
        g_lock    = sel ? bus.p1_lock : bus.p0_lock;
        lock_next = (grant && g_lock) ? LK_HELD : LK_IDLE;
    end
`else
    logic unused_lock;
    assign unused_lock = bus.p0_lock ^ bus.p1_lock ^ (LOCK_MAX > 0);
    assign lock_hold   = 1'b0;
`endif

    always_comb begin
        grant = !rst && (bus.p0_req || bus.p1_req);
        sel   = (bus.p0_req && bus.p1_req) ? !last : bus.p1_req;
`ifdef SRAM_ARB_LOCK_EN
        if (lock_hold)
            sel = lock_port;
`endif
        g_wen   = sel ? bus.p1_wen   : bus.p0_wen;
        g_addr  = sel ? bus.p1_addr  : bus.p0_addr;
        g_wdata = sel ? bus.p1_wdata : bus.p0_wdata;
    end

    always_comb begin
        bus.p0_gnt     = grant && !sel;
        bus.p1_gnt     = grant && sel;
        bus.sram_ren   = grant && (g_wen == '0);
        bus.sram_wen   = grant ? g_wen : '0;
        bus.sram_addr  = rst ? '0 : (grant ? g_addr  : bus.p0_addr);
        bus.sram_wdata = rst ? '0 : (grant ? g_wdata : bus.p0_wdata);
    end

    // Bytes written in the cycle before a read override the macro's stale data.
    always_comb begin
        merged = bus.sram_rdata;
        for (int unsigned b = 0; b < W_BE; b++) begin
            if (tag_mask[b])
                merged[b*8 +: 8] = tag_data[b*8 +: 8];
        end
    end

    always_comb begin
        bus.p0_rvalid = !rst && tag_valid && !tag_port;
        bus.p1_rvalid = !rst && tag_valid && tag_port;
        bus.p0_rdata  = bus.p0_rvalid ? merged : '0;
        bus.p1_rdata  = bus.p1_rvalid ? merged : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last      <= 1'b1;
            tag_valid <= 1'b0;
            tag_port  <= 1'b0;
            tag_mask  <= '0;
            tag_data  <= '0;
            fwd_valid <= 1'b0;
            fwd_addr  <= '0;
            fwd_data  <= '0;
            fwd_mask  <= '0;
        end else begin
            if (grant)
                last <= sel;
            tag_valid <= grant && (g_wen == '0);
            tag_port  <= sel;
            tag_mask  <= (fwd_valid && (fwd_addr == g_addr)) ? fwd_mask : '0;
            tag_data  <= fwd_data;
            fwd_valid <= grant && (g_wen != '0);
            fwd_addr  <= g_addr;
            fwd_data  <= g_wdata;
            fwd_mask  <= g_wen;
        end
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomised self-checking bench for sram_port_arbiter against a transaction-level model.
// The SRAM stand-in commits writes one cycle late, so only arbiter forwarding gives fresh data.
module tb_sram_port_arbiter;
    localparam int W_ADDR   = 11;
    localparam int W_DATA   = 32;
    localparam int LOCK_MAX = 4;
`ifdef SRAM_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    sram_port_arbiter_if #(.W_ADDR(W_ADDR), .W_DATA(W_DATA)) bus ();

    sram_port_arbiter #(.W_ADDR(W_ADDR), .W_DATA(W_DATA), .LOCK_MAX(LOCK_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int unsigned a);
        if (a == 16) return 32'hDEADBEEF;
        if (a == 5)  return 32'h11223344;
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // SRAM stand-in: 1-cycle read latency, write lands one edge after it is presented
    logic [31:0] mem [0:2047];
    logic [31:0] rd_q = '0;
    logic        pend_v = 1'b0;
    logic [3:0]  pend_be = '0;
    logic [10:0] pend_a = '0;
    logic [31:0] pend_d = '0;

    initial for (int i = 0; i < 2048; i++) mem[i] = init_word(i);

    always @(posedge clk) begin
        if (bus.sram_ren) rd_q <= mem[bus.sram_addr];
        if (pend_v)
            for (int b = 0; b < 4; b++)
                if (pend_be[b]) mem[pend_a][b*8 +: 8] <= pend_d[b*8 +: 8];
        pend_v  <= |bus.sram_wen;
        pend_be <= bus.sram_wen;
        pend_a  <= bus.sram_addr;
        pend_d  <= bus.sram_wdata;
    end
    assign bus.sram_rdata = rd_q;

    // Reference model: instantly-updated memory plus arbitration rules
    logic [31:0] ref_mem [0:2047];
    initial for (int i = 0; i < 2048; i++) ref_mem[i] = init_word(i);

    int          m_last = 1, m_lock_port = -1, m_streak = 0, m_pp = 0;
    bit          m_pv = 1'b0;
    logic [31:0] m_pd = '0;
    int          exp_g;
    bit          exp_rv0, exp_rv1, exp_ren;
    logic [31:0] exp_rd0, exp_rd1, exp_swdata;
    logic [3:0]  exp_swen;
    logic [10:0] exp_saddr;
    bit          c_act [2];

    task automatic model_step();
        logic [3:0]  wen;
        logic [10:0] addr;
        logic [31:0] wd;
        bit          lk, locked;
        exp_g = -1;
        if (!rst) begin
            if (bus.p0_req && bus.p1_req) begin
                exp_g = 1 - m_last;
                if (LOCK_EN && m_lock_port >= 0 && m_streak < LOCK_MAX) exp_g = m_lock_port;
            end else if (bus.p0_req) exp_g = 0;
            else if (bus.p1_req) exp_g = 1;
        end
        wen  = (exp_g == 1) ? bus.p1_wen   : bus.p0_wen;
        addr = (exp_g == 1) ? bus.p1_addr  : bus.p0_addr;
        wd   = (exp_g == 1) ? bus.p1_wdata : bus.p0_wdata;
        lk   = (exp_g == 1) ? bus.p1_lock  : bus.p0_lock;
        exp_rv0    = !rst && m_pv && m_pp == 0;
        exp_rv1    = !rst && m_pv && m_pp == 1;
        exp_rd0    = exp_rv0 ? m_pd : '0;
        exp_rd1    = exp_rv1 ? m_pd : '0;
        exp_ren    = exp_g >= 0 && wen == 4'b0;
        exp_swen   = exp_g >= 0 ? wen : 4'b0;
        exp_saddr  = rst ? '0 : addr;
        exp_swdata = rst ? '0 : wd;
        if (rst) begin
            m_last = 1; m_lock_port = -1; m_streak = 0; m_pv = 1'b0;
        end else begin
            m_pv = 1'b0;
            if (exp_g >= 0) begin
                if (wen == 4'b0) begin
                    m_pv = 1'b1; m_pp = exp_g; m_pd = ref_mem[addr];
                end else begin
                    for (int b = 0; b < 4; b++)
                        if (wen[b]) ref_mem[addr][b*8 +: 8] = wd[b*8 +: 8];
                end
                locked      = LOCK_EN && m_lock_port == exp_g;
                m_streak    = locked ? ((m_streak < LOCK_MAX) ? m_streak + 1 : m_streak) : 0;
                m_lock_port = (LOCK_EN && lk) ? exp_g : -1;
                m_last      = exp_g;
            end else begin
                m_lock_port = -1;
                m_streak    = 0;
            end
        end
    endtask

    task automatic set_port(input int p, input bit req, input logic [3:0] wen,
                            input logic [10:0] addr, input logic [31:0] wdata, input bit lock);
        if (p == 0) begin
            bus.p0_req = req; bus.p0_wen = wen; bus.p0_addr = addr; bus.p0_wdata = wdata; bus.p0_lock = lock;
        end else begin
            bus.p1_req = req; bus.p1_wen = wen; bus.p1_addr = addr; bus.p1_wdata = wdata; bus.p1_lock = lock;
        end
    endtask

    task automatic idle_ports();
        set_port(0, 1'b0, 4'b0, 11'h0, 32'h0, 1'b0);
        set_port(1, 1'b0, 4'b0, 11'h0, 32'h0, 1'b0);
    endtask

    task automatic drive_random(input int unsigned pct, input bit rd_only, input bit lock_ok);
        logic [3:0] wen;
        for (int p = 0; p < 2; p++) begin
            if (!c_act[p]) begin
                if ($urandom_range(99) < pct) begin
                    wen = (rd_only || $urandom_range(1) == 0) ? 4'b0 : 4'($urandom_range(15, 1));
                    set_port(p, 1'b1, wen, 11'($urandom_range(7)), $urandom, lock_ok && $urandom_range(3) == 0);
                    c_act[p] = 1'b1;
                end else begin
                    set_port(p, 1'b0, 4'b0, 11'($urandom_range(2047)), $urandom, 1'b0);
                end
            end
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        idle_ports();
        c_act[0] = 1'b0; c_act[1] = 1'b0;
        repeat (n) begin
            @(negedge clk); model_step();
            @(posedge clk); #1;
        end
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_port(0, 1'b1, 4'b0, 11'h010, 32'h0, 1'b0);
        set_port(1, 1'b1, 4'hF, 11'h003, 32'hA5A5A5A5, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); model_step();
            n_checks++;
            if ({bus.p0_gnt, bus.p1_gnt, bus.p0_rvalid, bus.p1_rvalid, bus.p0_rdata, bus.p1_rdata,
                 bus.sram_ren, bus.sram_wen, bus.sram_addr, bus.sram_wdata} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs cyc=%0d gnt=%b%b rv=%b%b ren=%b wen=%h addr=%h required all zero",
                         c, bus.p0_gnt, bus.p1_gnt, bus.p0_rvalid, bus.p1_rvalid, bus.sram_ren, bus.sram_wen, bus.sram_addr);
            end
            @(posedge clk); #1;
        end
        idle_ports();
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        set_port(0, 1'b1, 4'b0, 11'h010, 32'h0, 1'b0);
        @(negedge clk); model_step();
        n_checks++;
        if ({bus.p0_gnt, bus.p1_gnt, bus.sram_ren, bus.sram_addr} !== {1'b1, 1'b0, 1'b1, 11'h010}) begin
            n_fail++;
            $display("FAIL single_grant got gnt=%b%b ren=%b addr=%h required gnt=10 ren=1 addr=010",
                     bus.p0_gnt, bus.p1_gnt, bus.sram_ren, bus.sram_addr);
        end
        @(posedge clk); #1;
        idle_ports();
        @(negedge clk); model_step();
        n_checks++;
        if ({bus.p0_rvalid, bus.p1_rvalid, bus.p0_rdata, bus.p1_rdata} !== {2'b10, 32'hDEADBEEF, 32'h0}) begin
            n_fail++;
            $display("FAIL single_rdata got rv=%b%b d0=%h d1=%h required rv=10 d0=deadbeef d1=0",
                     bus.p0_rvalid, bus.p1_rvalid, bus.p0_rdata, bus.p1_rdata);
        end
        @(posedge clk); #1;
        @(negedge clk); model_step();
        n_checks++;
        if ({bus.p0_rvalid, bus.p1_rvalid} !== 2'b00) begin
            n_fail++;
            $display("FAIL single_rvalid_width got rv=%b%b required 00", bus.p0_rvalid, bus.p1_rvalid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_alternating_reads();
        do_reset(1);
        for (int c = 0; c < 12; c++) begin
            drive_random(100, 1'b1, 1'b0);
            @(negedge clk); model_step();
            n_checks++;
            if ({bus.p0_gnt, bus.p1_gnt} !== ((c % 2 == 0) ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL alt_order cyc=%0d got gnt=%b%b required %s", c, bus.p0_gnt, bus.p1_gnt,
                         (c % 2 == 0) ? "10" : "01");
            end
            n_checks++;
            if ({bus.p0_rvalid, bus.p1_rvalid, bus.p0_rdata, bus.p1_rdata} !== {exp_rv0, exp_rv1, exp_rd0, exp_rd1}) begin
                n_fail++;
                $display("FAIL alt_rdata cyc=%0d got rv=%b%b d0=%h d1=%h required rv=%b%b d0=%h d1=%h", c,
                         bus.p0_rvalid, bus.p1_rvalid, bus.p0_rdata, bus.p1_rdata, exp_rv0, exp_rv1, exp_rd0, exp_rd1);
            end
            if (exp_g >= 0) c_act[exp_g] = 1'b0;
            @(posedge clk); #1;
        end
        idle_ports();
        c_act[0] = 1'b0; c_act[1] = 1'b0;
        @(negedge clk); model_step();
        n_checks++;
        if ({bus.p0_rvalid, bus.p1_rvalid, bus.p0_rdata, bus.p1_rdata} !== {exp_rv0, exp_rv1, exp_rd0, exp_rd1}) begin
            n_fail++;
            $display("FAIL alt_drain got rv=%b%b d0=%h d1=%h required rv=%b%b d0=%h d1=%h",
                     bus.p0_rvalid, bus.p1_rvalid, bus.p0_rdata, bus.p1_rdata, exp_rv0, exp_rv1, exp_rd0, exp_rd1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_forward();
        set_port(1, 1'b1, 4'b0011, 11'h005, 32'hCAFEF00D, 1'b0);
        @(negedge clk); model_step();
        n_checks++;
        if ({bus.p1_gnt, bus.sram_ren, bus.sram_wen} !== {1'b1, 1'b0, 4'b0011}) begin
            n_fail++;
            $display("FAIL fwd_write got gnt1=%b ren=%b wen=%b required 1 0 0011", bus.p1_gnt, bus.sram_ren, bus.sram_wen);
        end
        @(posedge clk); #1;
        idle_ports();
        set_port(0, 1'b1, 4'b0, 11'h005, 32'h0, 1'b0);
        @(negedge clk); model_step();
        @(posedge clk); #1;
        idle_ports();
        @(negedge clk); model_step();
        n_checks++;
        if ({bus.p0_rvalid, bus.p0_rdata} !== {1'b1, 32'h1122F00D}) begin
            n_fail++;
            $display("FAIL fwd_merge got rv=%b d0=%h required rv=1 d0=1122f00d", bus.p0_rvalid, bus.p0_rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        set_port(0, 1'b1, 4'b0, 11'h010, 32'h0, 1'b0);
        @(negedge clk); model_step();
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk); model_step();
        n_checks++;
        if ({bus.p0_gnt, bus.p1_gnt, bus.p0_rvalid, bus.p1_rvalid, bus.p0_rdata, bus.p1_rdata,
             bus.sram_ren, bus.sram_wen, bus.sram_addr, bus.sram_wdata} !== '0) begin
            n_fail++;
            $display("FAIL midrst_outputs got gnt0=%b rv0=%b d0=%h ren=%b addr=%h required all zero",
                     bus.p0_gnt, bus.p0_rvalid, bus.p0_rdata, bus.sram_ren, bus.sram_addr);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); model_step();
        n_checks++;
        if ({bus.p0_gnt, bus.p0_rvalid} !== 2'b10) begin
            n_fail++;
            $display("FAIL midrst_tag_drop got gnt0=%b rv0=%b required gnt0=1 rv0=0", bus.p0_gnt, bus.p0_rvalid);
        end
        @(posedge clk); #1;
        idle_ports();
        @(negedge clk); model_step();
        n_checks++;
        if ({bus.p0_rvalid, bus.p0_rdata} !== {1'b1, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL midrst_reread got rv0=%b d0=%h required rv0=1 d0=deadbeef", bus.p0_rvalid, bus.p0_rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_lock();
        int seq [8];
        do_reset(1);
        for (int c = 0; c < 8; c++) seq[c] = LOCK_EN ? ((c == 5) ? 1 : 0) : (c % 2);
        set_port(0, 1'b1, 4'b0, 11'h010, 32'h0, 1'b1);
        set_port(1, 1'b1, 4'b0, 11'h020, 32'h0, 1'b0);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk); model_step();
            n_checks++;
            if ({bus.p0_gnt, bus.p1_gnt} !== {seq[c] == 0, seq[c] == 1}) begin
                n_fail++;
                $display("FAIL lock_order cyc=%0d got gnt=%b%b required port %0d", c, bus.p0_gnt, bus.p1_gnt, seq[c]);
            end
            n_checks++;
            if ({bus.p0_rvalid, bus.p1_rvalid, bus.p0_rdata, bus.p1_rdata} !== {exp_rv0, exp_rv1, exp_rd0, exp_rd1}) begin
                n_fail++;
                $display("FAIL lock_rdata cyc=%0d got rv=%b%b d0=%h d1=%h required rv=%b%b d0=%h d1=%h", c,
                         bus.p0_rvalid, bus.p1_rvalid, bus.p0_rdata, bus.p1_rdata, exp_rv0, exp_rv1, exp_rd0, exp_rd1);
            end
            @(posedge clk); #1;
        end
        idle_ports();
    endtask

    task automatic test_random();
        do_reset(1);
        for (int c = 0; c < 400; c++) begin
            drive_random(60, 1'b0, 1'b1);
            @(negedge clk); model_step();
            n_checks++;
            if ({bus.p0_gnt, bus.p1_gnt} !== {exp_g == 0, exp_g == 1}) begin
                n_fail++;
                $display("FAIL rand_gnt cyc=%0d got gnt=%b%b required gnt=%b%b", c,
                         bus.p0_gnt, bus.p1_gnt, exp_g == 0, exp_g == 1);
            end
            n_checks++;
            if ({bus.p0_rvalid, bus.p1_rvalid, bus.p0_rdata, bus.p1_rdata} !== {exp_rv0, exp_rv1, exp_rd0, exp_rd1}) begin
                n_fail++;
                $display("FAIL rand_rdata cyc=%0d got rv=%b%b d0=%h d1=%h required rv=%b%b d0=%h d1=%h", c,
                         bus.p0_rvalid, bus.p1_rvalid, bus.p0_rdata, bus.p1_rdata, exp_rv0, exp_rv1, exp_rd0, exp_rd1);
            end
            n_checks++;
            if ({bus.sram_ren, bus.sram_wen, bus.sram_addr, bus.sram_wdata} !== {exp_ren, exp_swen, exp_saddr, exp_swdata}) begin
                n_fail++;
                $display("FAIL rand_sram cyc=%0d got ren=%b wen=%b addr=%h wd=%h required ren=%b wen=%b addr=%h wd=%h", c,
                         bus.sram_ren, bus.sram_wen, bus.sram_addr, bus.sram_wdata, exp_ren, exp_swen, exp_saddr, exp_swdata);
            end
            if (exp_g >= 0) c_act[exp_g] = 1'b0;
            @(posedge clk); #1;
        end
        idle_ports();
    endtask

    initial begin
        idle_ports();
        c_act[0] = 1'b0; c_act[1] = 1'b0;
        test_reset();
        test_single_read();
        test_alternating_reads();
        test_forward();
        test_reset_mid();
        test_lock();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached after %0d checks", n_checks);
        $fatal(1, "time limit");
    end
endmodule
